// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge channel between the fetch unit and imem.
interface if_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: LoongArch IF stage. Owns the PC, runs the imem handshake and
// feeds the IF/ID register. Absorbs IF/ID stalls and EX redirects; a redirect
// with a request in flight drains the stale response in DROP.
// Build option: define IF_HOLD_BUF_EN to add the HOLD state and its instruction
// buffer; otherwise a stalled fetch is discarded and the same PC is re-requested.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_if,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    if_fetch_unit_if.master       imem,
    output logic                  valid_out,
    output logic [31:0]           pc_out,
    output logic [31:0]           inst_out,
    output logic [31:0]           pcadd4_out,
    output logic                  fetch_busy
);

    localparam int unsigned XLEN      = 32;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] ADDR_MASK = 32'hFFFF_FFFC;

`ifdef IF_HOLD_BUF_EN
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
`else
    typedef enum logic [1:0] {FETCH, DROP} state_t;
`endif

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic [XLEN-1:0]   drop_addr, drop_addr_n;
    logic [XLEN-1:0]   fetch_addr;
    logic              req;
    logic              valid;
    logic [XLEN-1:0]   inst;
`ifdef IF_HOLD_BUF_EN
    logic [XLEN-1:0]   hold_inst, hold_inst_n;
`endif

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop_addr <= '0;
`ifdef IF_HOLD_BUF_EN
            hold_inst <= '0;
`endif
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            drop_addr <= drop_addr_n;
`ifdef IF_HOLD_BUF_EN
            hold_inst <= hold_inst_n;
`endif
        end
    end

    // Next-state and fetch outputs; redirect takes priority over stall and ack.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_addr_n = drop_addr;
`ifdef IF_HOLD_BUF_EN
        hold_inst_n = hold_inst;
`endif
        fetch_addr  = pc;
        req         = 1'b0;
        valid       = 1'b0;
        inst        = imem.rdata;

        if (!rst) begin
            case (state)
                FETCH: begin
                    req   = 1'b1;
                    valid = imem.ack & ~redirect;
                    if (redirect) begin
                        pc_n = redirect_pc;
                        if (!imem.ack) begin
                            drop_addr_n = pc;
                            state_n     = DROP;
                        end
                    end else if (imem.ack) begin
                        if (!stall_if) begin
                            pc_n = pc + PC_STEP;
                        end
`ifdef IF_HOLD_BUF_EN
                        else begin
                            hold_inst_n = imem.rdata;
                            state_n     = HOLD;
                        end
`endif
                    end
                end
`ifdef IF_HOLD_BUF_EN
                HOLD: begin
                    valid = ~redirect;
                    inst  = hold_inst;
                    if (redirect) begin
                        pc_n    = redirect_pc;
                        state_n = FETCH;
                    end else if (!stall_if) begin
                        pc_n    = pc + PC_STEP;
                        state_n = FETCH;
                    end
                end
`endif
                DROP: begin
                    req        = 1'b1;
                    fetch_addr = drop_addr;
                    if (redirect) begin
                        pc_n = redirect_pc;
                    end else if (imem.ack) begin
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    // Memory request and IF/ID-facing outputs.
    always_comb begin
        imem.req   = req;
        imem.addr  = fetch_addr & ADDR_MASK;
        valid_out  = valid;
        fetch_busy = ~valid;
        inst_out   = inst;
        pc_out     = rst ? RESET_PC : pc;
        pcadd4_out = (rst ? RESET_PC : pc) + PC_STEP;
    end

endmodule
